// File: rtl/round_sequencer_if.sv
// Bundles the round sequencer's pushbutton, timer, comparator and display signals.
// Pure wiring: no storage, zero latency.
// No backpressure of its own; the compare request/ack pair is the only handshake.
interface round_sequencer_if;
    // Pushbutton, timer and comparator side (into the sequencer)
    logic       start;
    logic       confirm;
    logic       timer_zero;
    logic       cmp_ack;
    logic       cmp_eq;
    logic       cmp_lt;

    // Target, timer, comparator and display side (out of the sequencer)
    logic       target_load;
    logic       timer_load;
    logic       timer_run;
    logic       cmp_req;
    logic [2:0] round;
    logic [1:0] max_digits;
    logic [2:0] guesses_left;
    logic [1:0] hint;
    logic [1:0] win_lose;

    // Environment side: drives buttons/ack, watches the sequencer outputs
    modport master (
        output start, confirm, timer_zero, cmp_ack, cmp_eq, cmp_lt,
        input  target_load, timer_load, timer_run, cmp_req,
        input  round, max_digits, guesses_left, hint, win_lose
    );

    // Sequencer side
    modport slave (
        input  start, confirm, timer_zero, cmp_ack, cmp_eq, cmp_lt,
        output target_load, timer_load, timer_run, cmp_req,
        output round, max_digits, guesses_left, hint, win_lose
    );
endinterface

// File: rtl/round_sequencer.sv
// Game-flow FSM for the number-guessing game: rounds, guesses, hints, win/lose.
// All outputs registered; every reaction appears one clk after the sampled input.
// Compare request is held until cmp_ack; confirm is ignored unless waiting for entry.
module round_sequencer #(
    parameter int MAX_GUESSES = 5,
    parameter int NUM_ROUNDS  = 3,
    parameter int HINT_HOLD   = 25000000
) (
    input  logic              clk,
    input  logic              rst,
    round_sequencer_if.slave  bus
);

    localparam int HOLD_W = $clog2(HINT_HOLD + 1);

    // Last hold count value: a hold phase occupies exactly HINT_HOLD cycles.
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HINT_HOLD - 1);
    localparam logic [2:0]        GUESS_INIT = 3'(MAX_GUESSES);
    localparam logic [2:0]        ROUND_LAST = 3'(NUM_ROUNDS);

    localparam logic [1:0] HINT_NONE    = 2'b00;
    localparam logic [1:0] HINT_LOW     = 2'b01;
    localparam logic [1:0] HINT_HIGH    = 2'b10;
    localparam logic [1:0] HINT_CORRECT = 2'b11;

    localparam logic [1:0] RESULT_NONE = 2'b00;
    localparam logic [1:0] RESULT_WON  = 2'b01;
    localparam logic [1:0] RESULT_LOST = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ENTRY,
        S_COMPARE,
        S_HINT,
        S_RWIN,
        S_WIN,
        S_LOSE
    } state_t;

    state_t            state;
    logic [HOLD_W-1:0] hold_cnt;
    logic              target_load_r;
    logic              timer_load_r;
    logic              timer_run_r;
    logic              cmp_req_r;
    logic [2:0]        round_r;
    logic [2:0]        guesses_r;
    logic [1:0]        hint_r;
    logic [1:0]        win_lose_r;

    // Single sequencing process: state, hold counter and every registered output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            hold_cnt      <= '0;
            target_load_r <= 1'b0;
            timer_load_r  <= 1'b0;
            timer_run_r   <= 1'b0;
            cmp_req_r     <= 1'b0;
            round_r       <= '0;
            guesses_r     <= '0;
            hint_r        <= HINT_NONE;
            win_lose_r    <= RESULT_NONE;
        end else begin
            // Load strobes are single-cycle; they are re-asserted only on entry to LOAD.
            target_load_r <= 1'b0;
            timer_load_r  <= 1'b0;

            case (state)
                S_IDLE, S_WIN, S_LOSE: begin
                    // Finished or idle: only start matters, everything else stays frozen.
                    if (bus.start) begin
                        state         <= S_LOAD;
                        hold_cnt      <= '0;
                        round_r       <= 3'd1;
                        guesses_r     <= GUESS_INIT;
                        hint_r        <= HINT_NONE;
                        win_lose_r    <= RESULT_NONE;
                        target_load_r <= 1'b1;
                        timer_load_r  <= 1'b1;
                        timer_run_r   <= 1'b0;
                    end
                end

                S_LOAD: begin
                    // Target and timer were strobed during this cycle; start the clock.
                    state       <= S_ENTRY;
                    hold_cnt    <= '0;
                    timer_run_r <= 1'b1;
                end

                S_ENTRY: begin
                    // Timeout outranks a guess confirmed in the same cycle.
                    if (bus.timer_zero) begin
                        state       <= S_LOSE;
                        hold_cnt    <= '0;
                        timer_run_r <= 1'b0;
                        win_lose_r  <= RESULT_LOST;
                    end else if (bus.confirm) begin
                        state     <= S_COMPARE;
                        hold_cnt  <= '0;
                        cmp_req_r <= 1'b1;
                    end
                end

                S_COMPARE: begin
                    // Timer expiry is deliberately not sampled here so a guess in
                    // flight is always judged.
                    if (bus.cmp_ack) begin
                        cmp_req_r <= 1'b0;
                        hold_cnt  <= '0;
                        if (bus.cmp_eq) begin
                            state       <= S_RWIN;
                            hint_r      <= HINT_CORRECT;
                            timer_run_r <= 1'b0;
                        end else begin
                            hint_r <= bus.cmp_lt ? HINT_LOW : HINT_HIGH;
                            if (guesses_r != 3'd0) begin
                                guesses_r <= guesses_r - 3'd1;
                            end
                            // That was the last guess of the round.
                            if (guesses_r <= 3'd1) begin
                                state       <= S_LOSE;
                                timer_run_r <= 1'b0;
                                win_lose_r  <= RESULT_LOST;
                            end else begin
                                state <= S_HINT;
                            end
                        end
                    end
                end

                S_HINT: begin
                    // Hint stays on display while the timer keeps running.
                    if (bus.timer_zero) begin
                        state       <= S_LOSE;
                        hold_cnt    <= '0;
                        timer_run_r <= 1'b0;
                        win_lose_r  <= RESULT_LOST;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state    <= S_ENTRY;
                        hold_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end

                S_RWIN: begin
                    // Round won: show the result, then either finish or load the next round.
                    if (hold_cnt == HOLD_LAST) begin
                        hold_cnt <= '0;
                        if (round_r >= ROUND_LAST) begin
                            state      <= S_WIN;
                            win_lose_r <= RESULT_WON;
                        end else begin
                            state         <= S_LOAD;
                            round_r       <= round_r + 3'd1;
                            guesses_r     <= GUESS_INIT;
                            hint_r        <= HINT_NONE;
                            target_load_r <= 1'b1;
                            timer_load_r  <= 1'b1;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end

                default: begin
                    state    <= S_IDLE;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

    // Outputs come straight from registers; digits in play track the round number.
    assign bus.target_load  = target_load_r;
    assign bus.timer_load   = timer_load_r;
    assign bus.timer_run    = timer_run_r;
    assign bus.cmp_req      = cmp_req_r;
    assign bus.round        = round_r;
    assign bus.max_digits   = round_r[1:0];
    assign bus.guesses_left = guesses_r;
    assign bus.hint         = hint_r;
    assign bus.win_lose     = win_lose_r;

endmodule
